fuzz_result_checker: RTL and testbench
======================================

FUZZ_RESULT_CHECKER -- requirements
Module: fuzz_result_checker

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Ports, in order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a check run (sampled in IDLE or DONE)
- num_samples  input  8  samples expected per run, latched at start
- sample_valid  input  1  y_ref/y_dut hold a sample this cycle
- y_ref  input  246  expected top output (behavioural simulation)
- y_dut  input  246  observed top output (synthesized netlist)
- busy  output  1  run in progress
- done  output  1  run finished; results stable
- pass  output  1  no mismatch in completed run
- mismatch_count  output  8  mismatching samples, saturating
- first_mismatch_idx  output  8  index of first mismatching sample
- signature  output  32  MISR compaction of y_dut
REQ-003 Parameter SEED, default 32'hFFFFFFFF, MISR initial value.
REQ-004 Parameter POLY, default 32'h04C11DB7, MISR feedback polynomial.

Function
REQ-005 States: IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-006 IDLE or DONE with start=1 and num_samples!=0: latch num_samples, clear sample counter and mismatch_count, set first_mismatch_idx=8'hFF, signature=SEED, pass=0, next state RUN.
REQ-007 IDLE or DONE with start=1 and num_samples==0: clear as REQ-006, next state DONE, pass=1.
REQ-008 start SHALL be ignored in RUN.
REQ-009 RUN: a sample is accepted only on a cycle with sample_valid=1; cycles with sample_valid=0 change no state.
REQ-010 Accepted sample mismatches iff y_ref != y_dut over all 246 bits.
REQ-011 On a mismatch: mismatch_count increments, saturating at 8'hFF; if first_mismatch_idx==8'hFF it takes the current sample index (0-based, pre-increment counter value).
REQ-012 Fold: zero-extend y_dut to 256 bits; fold = XOR of its eight 32-bit slices.
REQ-013 Per accepted sample: signature <= {signature[30:0],1'b0} ^ (signature[31] ? POLY : 0) ^ fold.
REQ-014 When the accepted sample is index num_samples-1: next state DONE; pass <= (final mismatch_count==0), including the current sample; done=1 on the cycle after that sample's edge.
REQ-015 DONE holds all outputs stable until start or rst.
REQ-016 A sample with index 255 reaching first_mismatch_idx SHALL be indistinguishable from "none"; accepted limitation, documented for verification.
REQ-017 No combinational path from any input to any output; all outputs registered.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, busy=0, done=0, pass=0, mismatch_count=0, first_mismatch_idx=8'hFF, signature=SEED, sample counter=0, regardless of clk or state, including mid-RUN.
REQ-019 After rst deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-020 Reset: rst pulsed mid-RUN -> same cycle busy=0, done=0, pass=0, mismatch_count=0, first_mismatch_idx=FF, signature=FFFFFFFF.
REQ-021 Clean run: num_samples=3, three valid samples y_ref=y_dut=0 -> done one cycle after third, pass=1, mismatch_count=0, first_mismatch_idx=FF, signature=32'hE1B8AFFD.
REQ-022 Mismatch: num_samples=5, y_dut bit 0 flipped on sample 2 only -> pass=0, mismatch_count=1, first_mismatch_idx=2.
REQ-023 Empty run: start with num_samples=0 -> done=1 next cycle, pass=1, signature=FFFFFFFF, busy never 1.
REQ-024 Gaps and ignored start: num_samples=2, sample_valid toggled 1,0,0,1 with start=1 asserted in RUN -> exactly 2 samples counted, run not restarted, done after fourth cycle.
REQ-025 Saturation: num_samples=255 (8'hFF), all mismatching -> mismatch_count=FF, first_mismatch_idx=0, pass=0.

Source files
------------

// File: rtl/fuzz_result_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fuzz_result_checker                                           |
// | Purpose  : Compares a stream of reference vs. observed 246-bit samples   |
// |            for one run of num_samples, counts mismatches, records the    |
// |            first mismatching index and compacts y_dut into a 32-bit MISR.|
// | Ports    : clk, rst (async, active-high)                                 |
// |            start, num_samples[7:0]     - launch a run (IDLE/DONE only)   |
// |            sample_valid, y_ref, y_dut  - sample stream                   |
// |            busy, done, pass            - run status                      |
// |            mismatch_count[7:0]         - saturating mismatch count       |
// |            first_mismatch_idx[7:0]     - first bad index, FF when none   |
// |            signature[31:0]             - MISR of folded y_dut            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fuzz_result_checker #(
  parameter logic [31:0] SEED = 32'hFFFFFFFF,
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   num_samples,
  input  logic         sample_valid,
  input  logic [245:0] y_ref,
  input  logic [245:0] y_dut,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   mismatch_count,
  output logic [7:0]   first_mismatch_idx,
  output logic [31:0]  signature
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [7:0]   r_num;
  logic [7:0]   r_cnt;
  logic [7:0]   r_mm_cnt;
  logic [7:0]   r_first;
  logic [31:0]  r_sig;
  logic         r_pass;

  logic         w_launch;
  logic         w_accept;
  logic         w_last;
  logic         w_mismatch;
  logic [7:0]   w_mm_nxt;
  logic [255:0] w_ext;
  logic [31:0]  w_fold;
  logic [31:0]  w_sig_nxt;

  assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = (r_state == S_RUN) && sample_valid;
  assign w_last     = (r_cnt == (r_num - 8'd1));
  assign w_mismatch = (y_ref != y_dut);

  // Saturating increment keeps the count pinned at FF once reached.
  assign w_mm_nxt = (w_mismatch && (r_mm_cnt != 8'hFF)) ? (r_mm_cnt + 8'd1) : r_mm_cnt;

  // Fold the zero-extended observed sample down to one 32-bit word.
  always_comb begin
    w_ext  = {10'b0, y_dut};
    w_fold = 32'h0;
    for (int k = 0; k < 8; k++) begin
      w_fold = w_fold ^ w_ext[k*32 +: 32];
    end
  end

  assign w_sig_nxt = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_fold;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (num_samples == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (sample_valid && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode (from the state register only)
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Run datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num    <= 8'd0;
      r_cnt    <= 8'd0;
      r_mm_cnt <= 8'd0;
      r_first  <= 8'hFF;
      r_sig    <= SEED;
      r_pass   <= 1'b0;
    end else if (w_launch) begin
      r_num    <= num_samples;
      r_cnt    <= 8'd0;
      r_mm_cnt <= 8'd0;
      r_first  <= 8'hFF;
      r_sig    <= SEED;
      // An empty run completes immediately and is trivially clean.
      r_pass   <= (num_samples == 8'd0);
    end else if (w_accept) begin
      r_cnt    <= r_cnt + 8'd1;
      r_mm_cnt <= w_mm_nxt;
      r_sig    <= w_sig_nxt;
      // FF doubles as "none", so a mismatch at index 255 cannot be recorded.
      if (w_mismatch && (r_first == 8'hFF)) begin
        r_first <= r_cnt;
      end
      if (w_last) begin
        r_pass <= (w_mm_nxt == 8'd0);
      end
    end
  end

  assign pass               = r_pass;
  assign mismatch_count     = r_mm_cnt;
  assign first_mismatch_idx = r_first;
  assign signature          = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_result_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fuzz_result_checker                                        |
// | Purpose  : Self-checking bench for fuzz_result_checker. A queue-based    |
// |            model of each run predicts every output each cycle; directed |
// |            runs add literal expectations for clean, mismatch, empty,     |
// |            gapped, saturating and reset-mid-run cases.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fuzz_result_checker;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   num_samples = 8'd0;
  logic         sample_valid = 1'b0;
  logic [245:0] y_ref = '0;
  logic [245:0] y_dut = '0;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   mismatch_count;
  logic [7:0]   first_mismatch_idx;
  logic [31:0]  signature;

  int n_checks = 0;
  int n_err    = 0;

  fuzz_result_checker #(.SEED(SEED), .POLY(POLY)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .num_samples        (num_samples),
    .sample_valid       (sample_valid),
    .y_ref              (y_ref),
    .y_dut              (y_dut),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .mismatch_count     (mismatch_count),
    .first_mismatch_idx (first_mismatch_idx),
    .signature          (signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_fold(input logic [245:0] y);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 246; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [245:0] rnd246();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[245:0];
  endfunction

  // ---------------- model: one run = a list of accepted samples ------------
  int          m_phase = 0;   // 0 idle, 1 running, 2 finished
  int          m_num   = 0;
  bit          m_mm[$];
  logic [31:0] m_fold[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_num   = 0;
      m_mm.delete();
      m_fold.delete();
    end else if (m_phase != 1 && start) begin
      m_num = num_samples;
      m_mm.delete();
      m_fold.delete();
      m_phase = (num_samples == 8'd0) ? 2 : 1;
    end else if (m_phase == 1 && sample_valid) begin
      m_mm.push_back(y_ref != y_dut);
      m_fold.push_back(tb_fold(y_dut));
      if (m_mm.size() == m_num) m_phase = 2;
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(posedge clk) begin
    int          e_cnt;
    int          e_first;
    logic [31:0] e_sig;
    #1;
    if (!rst) begin
      e_cnt   = 0;
      e_first = 255;
      e_sig   = SEED;
      foreach (m_mm[i]) begin
        if (m_mm[i]) begin
          if (e_first == 255) e_first = i;
          if (e_cnt < 255) e_cnt++;
        end
        e_sig = {e_sig[30:0], 1'b0} ^ (e_sig[31] ? POLY : 32'h0) ^ m_fold[i];
      end
      check("busy",  {31'b0, busy}, {31'b0, m_phase == 1});
      check("done",  {31'b0, done}, {31'b0, m_phase == 2});
      check("pass",  {31'b0, pass}, {31'b0, (m_phase == 2) && (e_cnt == 0)});
      check("mm_cnt", {24'b0, mismatch_count}, e_cnt);
      check("first",  {24'b0, first_mismatch_idx}, e_first);
      check("sig",    signature, e_sig);
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [245:0] v;

    // Reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_first", {24'b0, first_mismatch_idx}, 32'hFF);
    check("rst_sig", signature, 32'hFFFFFFFF);
    nclk();
    rst = 1'b0;
    repeat (3) nclk();
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Clean run: three all-zero samples
    start = 1'b1; num_samples = 8'd3;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; y_ref = '0; y_dut = '0;
      nclk();
    end
    idle_inputs();
    check("clean_done", {31'b0, done}, 32'd1);
    check("clean_pass", {31'b0, pass}, 32'd1);
    check("clean_cnt", {24'b0, mismatch_count}, 32'd0);
    check("clean_first", {24'b0, first_mismatch_idx}, 32'hFF);
    check("clean_sig", signature, 32'hE1B8AFFD);
    nclk();

    // Single mismatch on sample 2 of 5
    start = 1'b1; num_samples = 8'd5;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = rnd246();
      sample_valid = 1'b1; y_ref = v; y_dut = v;
      if (i == 2) y_dut[0] = ~v[0];
      nclk();
    end
    idle_inputs();
    check("mm_done", {31'b0, done}, 32'd1);
    check("mm_pass", {31'b0, pass}, 32'd0);
    check("mm_cnt1", {24'b0, mismatch_count}, 32'd1);
    check("mm_first", {24'b0, first_mismatch_idx}, 32'd2);
    nclk();

    // Empty run
    start = 1'b1; num_samples = 8'd0;
    nclk();
    start = 1'b0;
    check("empty_done", {31'b0, done}, 32'd1);
    check("empty_busy", {31'b0, busy}, 32'd0);
    check("empty_pass", {31'b0, pass}, 32'd1);
    check("empty_sig", signature, 32'hFFFFFFFF);
    nclk();

    // Gaps with start held in RUN; both samples mismatch
    start = 1'b1; num_samples = 8'd2;
    nclk();
    num_samples = 8'd9;
    sample_valid = 1'b1; y_ref = rnd246(); y_dut = ~y_ref;
    nclk();
    sample_valid = 1'b0;
    nclk();
    start = 1'b0;
    nclk();
    check("gap_busy", {31'b0, busy}, 32'd1);
    check("gap_notdone", {31'b0, done}, 32'd0);
    sample_valid = 1'b1; y_ref = rnd246(); y_dut = y_ref ^ 246'd5;
    nclk();
    idle_inputs();
    check("gap_done", {31'b0, done}, 32'd1);
    check("gap_cnt", {24'b0, mismatch_count}, 32'd2);
    check("gap_first", {24'b0, first_mismatch_idx}, 32'd0);
    nclk();

    // 255 samples, every one mismatching
    start = 1'b1; num_samples = 8'hFF;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      sample_valid = 1'b1; y_ref = rnd246(); y_dut = y_ref ^ (246'd1 << (i % 246));
      nclk();
    end
    idle_inputs();
    check("sat_done", {31'b0, done}, 32'd1);
    check("sat_cnt", {24'b0, mismatch_count}, 32'hFF);
    check("sat_first", {24'b0, first_mismatch_idx}, 32'd0);
    check("sat_pass", {31'b0, pass}, 32'd0);
    nclk();

    // Reset asserted mid-run, between clock edges
    start = 1'b1; num_samples = 8'd10;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; y_ref = rnd246(); y_dut = (i == 1) ? ~y_ref : y_ref;
      nclk();
    end
    idle_inputs();
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_pass", {31'b0, pass}, 32'd0);
    check("mrst_cnt", {24'b0, mismatch_count}, 32'd0);
    check("mrst_first", {24'b0, first_mismatch_idx}, 32'hFF);
    check("mrst_sig", signature, 32'hFFFFFFFF);
    nclk();
    rst = 1'b0;
    sample_valid = 1'b1; y_ref = rnd246(); y_dut = ~y_ref;
    repeat (3) nclk();
    idle_inputs();
    check("post_rst_idle", {30'b0, busy, done}, 32'd0);
    check("post_rst_cnt", {24'b0, mismatch_count}, 32'd0);

    // A final short run starting from IDLE after reset
    start = 1'b1; num_samples = 8'd1;
    nclk();
    start = 1'b0;
    sample_valid = 1'b1; y_ref = rnd246(); y_dut = y_ref;
    nclk();
    idle_inputs();
    check("last_done", {31'b0, done}, 32'd1);
    check("last_pass", {31'b0, pass}, 32'd1);
    repeat (2) nclk();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
